// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I core: sequences fetch, decode, execute,
// memory and writeback over a shared datapath, with ready-qualified memory accesses.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic [2:0] Funct3,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       FunctZero,
  output logic       PCSource,
  output logic       InstrDone,
  output logic       IllegalInstr
);

  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StExecI   = 4'd3,
    StAluWb   = 4'd4,
    StMemAdr  = 4'd5,
    StMemRd   = 4'd6,
    StMemWb   = 4'd7,
    StMemWr   = 4'd8,
    StBranch  = 4'd9,
    StIllegal = 4'd10
  } state_e;

  state_e r_state;
  state_e w_state_next;

  always_ff @(posedge clk) begin
    if (reset) r_state <= StFetch;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = StFetch;
    PCEn         = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    FunctZero    = 1'b0;
    PCSource     = 1'b0;
    InstrDone    = 1'b0;
    IllegalInstr = 1'b0;

    case (r_state)
      StFetch: begin
        MemRead      = 1'b1;
        ALUSrcB      = 2'b01;
        FunctZero    = 1'b1;
        IRWrite      = MemReady;
        PCEn         = MemReady;
        w_state_next = MemReady ? StDecode : StFetch;
      end
      StDecode: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        FunctZero = 1'b1;
        // lh/sh would reach the ALU decoder as a shift; only beq/bne are implemented
        case (Opcode)
          OpRType:          w_state_next = StExecR;
          OpIType:          w_state_next = StExecI;
          OpLoad, OpStore:  w_state_next = (Funct3 == 3'b001) ? StIllegal : StMemAdr;
          OpBranch:         w_state_next = (Funct3[2:1] == 2'b00) ? StBranch : StIllegal;
          default:          w_state_next = StIllegal;
        endcase
      end
      StExecR: begin
        ALUSrcA      = 2'b10;
        ALUOp        = 2'b10;
        w_state_next = StAluWb;
      end
      StExecI: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b10;
        w_state_next = StAluWb;
      end
      StAluWb: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      StMemAdr: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b10;
        FunctZero    = 1'b1;
        w_state_next = (Opcode == OpLoad) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        MemRead      = 1'b1;
        IorD         = 1'b1;
        w_state_next = MemReady ? StMemWb : StMemRd;
      end
      StMemWb: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        InstrDone = 1'b1;
      end
      StMemWr: begin
        MemWrite     = 1'b1;
        IorD         = 1'b1;
        InstrDone    = MemReady;
        w_state_next = MemReady ? StFetch : StMemWr;
      end
      StBranch: begin
        ALUSrcA   = 2'b10;
        ALUOp     = 2'b01;
        PCSource  = 1'b1;
        InstrDone = 1'b1;
        PCEn      = ~(Zero ^ ~Funct3[0]);
      end
      StIllegal: begin
        IllegalInstr = 1'b1;
        InstrDone    = 1'b1;
      end
      default: w_state_next = StFetch;
    endcase

    // Strobes must be quiet during reset even though they are combinational
    if (reset) begin
      PCEn         = 1'b0;
      IorD         = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      MemtoReg     = 1'b0;
      RegWrite     = 1'b0;
      ALUSrcA      = 2'b00;
      ALUSrcB      = 2'b00;
      ALUOp        = 2'b00;
      FunctZero    = 1'b0;
      PCSource     = 1'b0;
      InstrDone    = 1'b0;
      IllegalInstr = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: instruction-level reference model builds the
// expected per-cycle control word from the instruction class and memory wait schedule.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Opcode;
  logic [2:0] Funct3;
  logic       Zero;
  logic       MemReady;
  logic       PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp;
  logic       FunctZero, PCSource, InstrDone, IllegalInstr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk          (clk),
    .reset        (reset),
    .Opcode       (Opcode),
    .Funct3       (Funct3),
    .Zero         (Zero),
    .MemReady     (MemReady),
    .PCEn         (PCEn),
    .IorD         (IorD),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .MemtoReg     (MemtoReg),
    .RegWrite     (RegWrite),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ALUOp        (ALUOp),
    .FunctZero    (FunctZero),
    .PCSource     (PCSource),
    .InstrDone    (InstrDone),
    .IllegalInstr (IllegalInstr)
  );

  // {PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
  //  ALUSrcA, ALUSrcB, ALUOp, FunctZero, PCSource, InstrDone, IllegalInstr}
  logic [17:0] w_outs;
  assign w_outs = {PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
                   ALUSrcA, ALUSrcB, ALUOp, FunctZero, PCSource, InstrDone, IllegalInstr};

  localparam int SFetch = 0, SDecode = 1, SExecR = 2, SExecI = 3, SAluWb = 4, SMemAdr = 5;
  localparam int SMemRd = 6, SMemWb = 7, SMemWr = 8, SBranch = 9, SIll = 10;
  localparam int CR = 0, CI = 1, CLd = 2, CSt = 3, CBr = 4, CIll = 5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int classify(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0110011: return CR;
      7'b0010011: return CI;
      7'b0000011: return (f3 == 3'b001) ? CIll : CLd;
      7'b0100011: return (f3 == 3'b001) ? CIll : CSt;
      7'b1100011: return (f3 == 3'b000 || f3 == 3'b001) ? CBr : CIll;
      default:    return CIll;
    endcase
  endfunction

  function automatic logic [17:0] exp_vec(input int s, input bit rdy, input bit z,
                                          input logic [2:0] f3);
    bit pcen = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rw = 0;
    bit fz = 0, pcs = 0, done = 0, ill = 0;
    logic [1:0] sa = 2'b00, sb = 2'b00, op = 2'b00;
    case (s)
      SFetch:  begin mrd = 1; sb = 2'b01; fz = 1; irw = rdy; pcen = rdy; end
      SDecode: begin sa = 2'b01; sb = 2'b10; fz = 1; end
      SExecR:  begin sa = 2'b10; op = 2'b10; end
      SExecI:  begin sa = 2'b10; sb = 2'b10; end
      SAluWb:  begin rw = 1; done = 1; end
      SMemAdr: begin sa = 2'b10; sb = 2'b10; fz = 1; end
      SMemRd:  begin mrd = 1; iord = 1; end
      SMemWb:  begin rw = 1; m2r = 1; done = 1; end
      SMemWr:  begin mwr = 1; iord = 1; done = rdy; end
      SBranch: begin
        sa = 2'b10; op = 2'b01; pcs = 1; done = 1;
        pcen = f3[0] ? !z : z;  // beq taken on equal, bne on not-equal
      end
      default: begin ill = 1; done = 1; end
    endcase
    return {pcen, iord, mrd, mwr, irw, m2r, rw, sa, sb, op, fz, pcs, done, ill};
  endfunction

  // data_waits < 0: random MemReady everywhere; >= 0: fetch ready at once, data step
  // waits exactly that many cycles. zero_mode < 0: random Zero.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int data_waits,
                           input bit abort_rd, input int zero_mode);
    int q[$];
    int cls, base, cyc, done_cyc, waits;
    string sname[11] = '{"fetch", "decode", "exec_r", "exec_i", "alu_wb", "memadr",
                         "mem_rd", "mem_wb", "mem_wr", "branch", "illegal"};
    cls = classify(op, f3);
    q = '{SFetch, SDecode};
    case (cls)
      CR:      begin q.push_back(SExecR); q.push_back(SAluWb); base = 4; end
      CI:      begin q.push_back(SExecI); q.push_back(SAluWb); base = 4; end
      CLd:     begin q.push_back(SMemAdr); q.push_back(SMemRd); q.push_back(SMemWb); base = 5; end
      CSt:     begin q.push_back(SMemAdr); q.push_back(SMemWr); base = 4; end
      CBr:     begin q.push_back(SBranch); base = 3; end
      default: begin q.push_back(SIll); base = 3; end
    endcase
    cyc = 0; done_cyc = -1; waits = 0;
    foreach (q[k]) begin
      int s = q[k];
      int w = 0;
      forever begin
        bit is_mem, rdy;
        @(negedge clk);
        Opcode = op;
        Funct3 = f3;
        Zero   = (zero_mode < 0) ? 1'($urandom_range(0, 1)) : 1'(zero_mode);
        is_mem = (s == SFetch || s == SMemRd || s == SMemWr);
        if (!is_mem)             rdy = 1'($urandom_range(0, 1));
        else if (data_waits < 0) rdy = (w >= 3) || ($urandom_range(0, 2) != 0);
        else if (s == SFetch)    rdy = 1'b1;
        else                     rdy = (w >= data_waits);
        if (abort_rd && s == SMemRd) begin
          reset    = 1'b1;
          MemReady = 1'b1;
          #1;
          check("abort_outs", 32'(w_outs), 32'd0);
          @(posedge clk);
          #1 reset = 1'b0;
          return;
        end
        MemReady = rdy;
        #1;
        check(sname[s], 32'(w_outs), 32'(exp_vec(s, rdy, Zero, f3)));
        if (InstrDone && done_cyc < 0) done_cyc = cyc;
        cyc++;
        if (!is_mem || rdy) break;
        w++;
        waits++;
      end
    end
    check("latency", 32'(done_cyc + 1), 32'(base + waits));
  endtask

  logic [6:0] ops[6] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0};

  initial begin
    reset    = 1'b1;
    MemReady = 1'b1;
    Opcode   = 7'b0110011;
    Funct3   = 3'b000;
    Zero     = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 check("reset_outs", 32'(w_outs), 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;

    run_instr(7'b0110011, 3'b000, 0, 1'b0, -1);  // add
    run_instr(7'b0000011, 3'b010, 2, 1'b0, -1);  // lw, two wait states
    run_instr(7'b0100011, 3'b010, 0, 1'b0, -1);  // sw
    run_instr(7'b1100011, 3'b000, 0, 1'b0, 1);   // beq, taken
    run_instr(7'b1100011, 3'b001, 0, 1'b0, 1);   // bne, not taken
    run_instr(7'b0010011, 3'b001, 0, 1'b0, -1);  // slli
    run_instr(7'b1111111, 3'b000, 0, 1'b0, -1);  // unknown opcode
    run_instr(7'b0000011, 3'b001, 0, 1'b0, -1);  // lh
    run_instr(7'b0000011, 3'b010, 0, 1'b1, -1);  // lw aborted by reset
    run_instr(7'b0110011, 3'b111, 0, 1'b0, -1);  // restart from fetch

    for (int i = 0; i < 300; i++) begin
      logic [6:0] op;
      op = ops[$urandom_range(0, 5)];
      if (op == 7'b0) op = 7'($urandom);
      run_instr(op, 3'($urandom), -1, 1'b0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
